serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: the complementary arithmetic block to the team's combinational full subtractor.
- Operands are loaded in parallel and processed LSB-first through a single full-adder cell with a registered carry.
- The result is presented in parallel with a start/busy/done handshake.
- Used where area matters more than latency; feeds datapath blocks that accept a done-qualified result.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin an addition; sampled on rising edge.
- a  input  WIDTH  operand A; captured only when start is accepted.
- b  input  WIDTH  operand B; captured only when start is accepted.
- cin  input  1  carry-in; captured only when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse: sum/cout updated and valid.
- sum  output  WIDTH  registered result (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter are cleared.
  - Any in-flight operation is discarded.
- FSM states:
  - IDLE: busy=0, done=0. On start=1, load a/b into shift registers, carry flop <= cin, cnt <= 0, go to RUN.
  - RUN: busy=1, done=0. Each cycle:
    - s = A[0]^B[0]^c.
    - c <= majority(A[0],B[0],c).
    - Shift A and B right by one.
    - Shift s into the MSB of the result shift register.
    - cnt++.
    - When cnt==WIDTH-1, this cycle processes the final bit: transfer the completed result to sum, the final carry to cout, and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 here: accept new operands exactly as in IDLE, go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Latency: start sampled at edge E0.
  - busy is high from E0 to E0+WIDTH.
  - done is high from E0+WIDTH to E0+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles with continuous start.
- sum/cout change only at the edge entering DONE. They hold their value through IDLE and through the following RUN until the next DONE.
- start while in RUN is ignored: no restart, no queueing.
- a, b and cin changes after acceptance have no effect on the result.
- Arithmetic is unsigned. Overflow appears only in cout; sum wraps modulo 2^WIDTH.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (WIDTH=8 unless noted):
1. After reset, check outputs = 0. Then a=8'h3C, b=8'h42, cin=0, start for 1 cycle -> busy high 8 cycles; done pulses once at the 8th edge after start; sum=8'h7E, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Also check sum holds 8'h00 in the idle cycles between the two operations.
3. Start a=8'h10, b=8'h20, cin=0. During RUN, change a/b to 8'hFF and pulse start twice -> result sum=8'h30, cout=0; exactly one done pulse; no extra operation afterwards.
4. Hold start=1 continuously with a new operand pair presented in each DONE cycle: (8'h01,8'h01,0), (8'h80,8'h80,0), (8'h7F,8'h00,1) -> done every 9 cycles. Results in order: 8'h02/0, 8'h00/1, 8'h80/0.
5. Start a=8'hF0, b=8'h0F, cin=1; assert rst at cycle 4 of RUN -> busy, done, sum and cout go 0 immediately, with no done pulse. After release, a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
6. WIDTH=4 exhaustive: all 512 combinations of a, b, cin -> {cout,sum} equals a+b+cin for each; every done is 4 cycles after its start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are loaded in parallel and summed LSB-first through one
// full-adder cell with a registered carry. The result is presented in parallel with a done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  // Encoding chosen so busy and done come straight from state flops.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             s_bit, c_next;

  always_comb begin
    s_bit  = a_q[0] ^ b_q[0] ^ c_q;
    c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;

    case (state_q)
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        res_d = {s_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; start during RUN is ignored.
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = state_q[0];
  assign done = state_q[1];
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake/timing cases and a 4-bit
// instance swept over every operand combination.
module tb_serial_adder;

  logic       clk;
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst4, start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation from IDLE/DONE; done must appear exactly 8 edges after acceptance.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] exp_sum, input logic exp_cout, input string tag);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, " busy@E0"}, 32'({busy8, done8}), 32'h2);
    for (int i = 1; i < 8; i++) begin
      tick();
      check({tag, " running"}, 32'({busy8, done8}), 32'h2);
    end
    tick();
    check({tag, " done"}, 32'({busy8, done8}), 32'h1);
    check({tag, " sum"}, 32'(sum8), 32'(exp_sum));
    check({tag, " cout"}, 32'(cout8), 32'(exp_cout));
  endtask

  initial begin
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick();
    tick();
    rst8 = 1'b0;
    rst4 = 1'b0;
    tick();

    // 1: reset state, then a basic add
    check("reset busy/done", 32'({busy8, done8}), 32'h0);
    check("reset sum", 32'(sum8), 32'h0);
    check("reset cout", 32'(cout8), 32'h0);
    run8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "t1");
    tick();
    check("t1 idle after done", 32'({busy8, done8}), 32'h0);

    // 2: overflow, result held through idle, carry-in overflow
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2 hold sum", 32'(sum8), 32'h00);
      check("t2 hold cout", 32'(cout8), 32'h1);
    end
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "t2b");
    tick();

    // 3: operand changes and start pulses during RUN are ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      start8 = (i == 2 || i == 4);
      tick();
      if (i < 8) check("t3 running", 32'({busy8, done8}), 32'h2);
    end
    start8 = 1'b0;
    check("t3 done", 32'({busy8, done8}), 32'h1);
    check("t3 sum", 32'(sum8), 32'h30);
    check("t3 cout", 32'(cout8), 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t3 no extra op", 32'({busy8, done8}), 32'h0);
    end
    check("t3 sum held", 32'(sum8), 32'h30);

    // 4: continuous start, new operands presented in each DONE cycle
    begin
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic       vc [3];
      logic [7:0] es [3];
      logic       ec [3];
      va = '{8'h01, 8'h80, 8'h7F}; vb = '{8'h01, 8'h80, 8'h00}; vc = '{1'b0, 1'b0, 1'b1};
      es = '{8'h02, 8'h00, 8'h80}; ec = '{1'b0, 1'b1, 1'b0};
      start8 = 1'b1;
      for (int k = 0; k < 3; k++) begin
        a8 = va[k]; b8 = vb[k]; cin8 = vc[k];
        tick();
        check("t4 busy", 32'({busy8, done8}), 32'h2);
        for (int i = 1; i < 8; i++) tick();
        a8 = 8'hFF; b8 = 8'hFF;
        tick();
        check("t4 done", 32'({busy8, done8}), 32'h1);
        check("t4 sum", 32'(sum8), 32'(es[k]));
        check("t4 cout", 32'(cout8), 32'(ec[k]));
      end
      start8 = 1'b0;
      tick();
      check("t4 idle", 32'({busy8, done8}), 32'h0);
    end

    // 5: asynchronous reset mid-operation
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t5 busy before rst", 32'(busy8), 32'h1);
    rst8 = 1'b1;
    #1;
    check("t5 rst busy/done", 32'({busy8, done8}), 32'h0);
    check("t5 rst sum", 32'(sum8), 32'h0);
    check("t5 rst cout", 32'(cout8), 32'h0);
    tick();
    rst8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5 no done", 32'({busy8, done8}), 32'h0);
    end
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "t5");
    tick();

    // 6: exhaustive 4-bit sweep, back-to-back from DONE
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          logic [4:0] exp5;
          exp5 = 5'(av) + 5'(bv) + 5'(cv);
          a4 = 4'(av); b4 = 4'(bv); cin4 = cv[0]; start4 = 1'b1;
          tick();
          start4 = 1'b0;
          for (int i = 1; i < 4; i++) begin
            tick();
            check("t6 early done", 32'(done4), 32'h0);
          end
          tick();
          check("t6 done", 32'(done4), 32'h1);
          check("t6 result", 32'({cout4, sum4}), 32'(exp5));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
